// File: rtl/seg_scan_arbiter.sv
// rtl/seg_scan_arbiter.sv - two-client round-robin owner of an 8-digit active-low 7-segment scan
module seg_scan_arbiter #(
   parameter int SCAN_DIV    = 200000,
   parameter int HOLD_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [31:0] frame0,
   input  logic [31:0] frame1,
   input  logic [7:0]  dp0,
   input  logic [7:0]  dp1,
   output logic [1:0]  grant,
   output logic [7:0]  led_en,
   output logic        led_ca,
   output logic        led_cb,
   output logic        led_cc,
   output logic        led_cd,
   output logic        led_ce,
   output logic        led_cf,
   output logic        led_cg,
   output logic        led_dp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t          state, state_nx;
   logic            last;
   logic [DW-1:0]   div_cnt;
   logic [2:0]      idx, idx_nx;
   logic [HW-1:0]   hold_cnt, hold_inc;
   logic            tick, sweep_done, hold_met, changed, load;
   logic [31:0]     frame_sel;
   logic [7:0]      dp_sel;
   logic [3:0]      nibble;
   logic [6:0]      seg;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   always_comb begin
      tick       = (div_cnt == DIV_MAX);
      sweep_done = tick && (idx == 3'd7);
      hold_inc   = (hold_cnt >= HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      // the switch fires on the sweep that brings the count up to the limit
      hold_met   = sweep_done && (hold_inc >= HOLD_MAX);
      state_nx   = state;
      case (state)
         IDLE: begin
            if (req == 2'b11)  state_nx = last ? OWN0 : OWN1;
            else if (req[0])   state_nx = OWN0;
            else if (req[1])   state_nx = OWN1;
         end
         OWN0: begin
            if (!req[0])                 state_nx = req[1] ? OWN1 : IDLE;
            else if (req[1] && hold_met) state_nx = OWN1;
         end
         OWN1: begin
            if (!req[1])                 state_nx = req[0] ? OWN0 : IDLE;
            else if (req[0] && hold_met) state_nx = OWN0;
         end
         default: state_nx = IDLE;
      endcase
      changed   = (state_nx != state);
      load      = changed || tick;
      idx_nx    = changed ? 3'd0 : (tick ? idx + 3'd1 : idx);
      frame_sel = (state_nx == OWN1) ? frame1 : frame0;
      dp_sel    = (state_nx == OWN1) ? dp1 : dp0;
      nibble    = frame_sel[{idx_nx, 2'b00} +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         div_cnt  <= '0;
         idx      <= '0;
         hold_cnt <= '0;
         grant    <= 2'b00;
         led_en   <= 8'hFF;
         seg      <= 7'h7F;
         led_dp   <= 1'b1;
      end else begin
         state <= state_nx;
         grant <= {state_nx == OWN1, state_nx == OWN0};
         if (changed) begin
            if (state_nx != IDLE) last <= (state_nx == OWN1);
            div_cnt  <= '0;
            idx      <= '0;
            hold_cnt <= '0;
         end else if (state != IDLE) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            idx     <= idx_nx;
            if (sweep_done) hold_cnt <= hold_inc;
         end
         // digit content is captured only when a digit starts, then held
         if (state_nx == IDLE) begin
            led_en <= 8'hFF;
            seg    <= 7'h7F;
            led_dp <= 1'b1;
         end else if (load) begin
            led_en <= ~(8'd1 << idx_nx);
            seg    <= hex7(nibble);
            led_dp <= ~dp_sel[idx_nx];
         end
      end
   end

   assign {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg} = seg;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb/tb_seg_scan_arbiter.sv - randomized and directed bench for seg_scan_arbiter against a time-based model
module tb_seg_scan_arbiter;

   localparam int SD = 4;
   localparam int HF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [31:0] frame0 = 32'h0, frame1 = 32'h0;
   logic [7:0]  dp0 = 8'h0, dp1 = 8'h0;
   logic [1:0]  grant;
   logic [7:0]  led_en;
   logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

   int checks = 0;
   int errors = 0;

   seg_scan_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
      .clk(clk), .rst(rst), .req(req),
      .frame0(frame0), .frame1(frame1), .dp0(dp0), .dp1(dp1),
      .grant(grant), .led_en(led_en),
      .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
      .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
   );

   always #5 clk = ~clk;

   logic [6:0] hexlut [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // model: owner (-1 idle), last owner, cycles elapsed since the grant began
   int         m_own  = -1;
   int         m_last = 1;
   int         m_t    = 0;
   logic [7:0] m_en   = 8'hFF;
   logic [6:0] m_seg  = 7'h7F;
   logic       m_dp   = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic show(input int d);
      logic [31:0] f;
      logic [7:0]  p;
      f = (m_own == 1) ? frame1 : frame0;
      p = (m_own == 1) ? dp1 : dp0;
      m_en  = ~(8'd1 << d);
      m_seg = hexlut[f[4*d +: 4]];
      m_dp  = ~p[d];
   endtask

   task automatic blank();
      m_own = -1;
      m_en  = 8'hFF;
      m_seg = 7'h7F;
      m_dp  = 1'b1;
   endtask

   task automatic start(input int c);
      m_own  = c;
      m_last = c;
      m_t    = 0;
      show(0);
   endtask

   task automatic step(input logic r, input logic [1:0] q);
      int y;
      if (r) begin
         blank();
         m_last = 1;
         m_t    = 0;
      end else if (m_own < 0) begin
         if (q == 2'b11)  start(1 - m_last);
         else if (q[0])   start(0);
         else if (q[1])   start(1);
      end else begin
         y = 1 - m_own;
         if (!q[m_own]) begin
            if (q[y]) start(y);
            else      blank();
         end else if (q[y] && ((m_t + 1) % (8*SD)) == 0 && ((m_t + 1) / (8*SD)) >= HF) begin
            start(y);
         end else begin
            m_t++;
            if (m_t % SD == 0) show((m_t / SD) % 8);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] q);
      logic [1:0] eg;
      @(negedge clk);
      rst = r;
      req = q;
      step(r, q);
      @(posedge clk);
      #1;
      eg = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
      check("grant", {30'd0, grant}, {30'd0, eg});
      check("led_en", {24'd0, led_en}, {24'd0, m_en});
      check("seg", {25'd0, led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg}, {25'd0, m_seg});
      check("led_dp", {31'd0, led_dp}, {31'd0, m_dp});
   endtask

   function automatic logic [6:0] segs();
      return {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg};
   endfunction

   initial begin
      frame0 = $urandom; frame1 = $urandom; dp0 = 8'($urandom); dp1 = 8'($urandom);
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'($urandom));
      check("rst_en", {24'd0, led_en}, 32'hFF);
      check("rst_seg", {25'd0, segs()}, 32'h7F);

      frame0 = 32'h76543210; dp0 = 8'h01;
      cyc(1'b0, 2'b01);
      check("s2_grant", {30'd0, grant}, 32'd1);
      check("s2_en", {24'd0, led_en}, 32'hFE);
      check("s2_seg", {25'd0, segs()}, 32'h01);
      check("s2_dp", {31'd0, led_dp}, 32'd0);
      for (int i = 0; i < 40; i++) cyc(1'b0, 2'b01);

      cyc(1'b1, 2'b00);
      frame1 = 32'hFFFFFFFF;
      for (int i = 0; i < 64; i++) cyc(1'b0, 2'b11);
      check("s3_hold", {30'd0, grant}, 32'd1);
      cyc(1'b0, 2'b11);
      check("s3_switch", {30'd0, grant}, 32'd2);
      check("s3_seg", {25'd0, segs()}, 32'h38);
      for (int i = 0; i < 64; i++) cyc(1'b0, 2'b11);
      check("s3_back", {30'd0, grant}, 32'd1);

      cyc(1'b1, 2'b00);
      frame0 = $urandom; frame1 = $urandom;
      for (int i = 0; i < 13; i++) cyc(1'b0, 2'b01);
      cyc(1'b0, 2'b10);
      check("s4_grant", {30'd0, grant}, 32'd2);
      check("s4_en", {24'd0, led_en}, 32'hFE);
      cyc(1'b0, 2'b00);
      check("s5_grant", {30'd0, grant}, 32'd0);
      check("s5_en", {24'd0, led_en}, 32'hFF);

      cyc(1'b1, 2'b00);
      for (int i = 0; i < 21; i++) cyc(1'b0, 2'b11);
      cyc(1'b1, 2'b11);
      check("s6_blank", {24'd0, led_en}, 32'hFF);
      cyc(1'b0, 2'b11);
      check("s6_grant", {30'd0, grant}, 32'd1);
      check("s6_en", {24'd0, led_en}, 32'hFE);

      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [1:0] q;
         q = req;
         if ($urandom_range(0, 19) == 0) q = 2'($urandom);
         r = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) frame0 = $urandom;
         if ($urandom_range(0, 3) == 0) frame1 = $urandom;
         if ($urandom_range(0, 7) == 0) dp0 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) dp1 = 8'($urandom);
         cyc(r, q);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
